// File: rtl/posit_decode_stage_pkg.sv
// Shared definitions for the posit decode path: default format, width helpers,
// NaR pattern and the per-word result class used by the second stage.
package posit_decode_stage_pkg;

  localparam int POSIT_N_DEF  = 16;
  localparam int POSIT_ES_DEF = 1;

  typedef enum logic [1:0] {
    CLS_NORMAL = 2'd0,
    CLS_ZERO   = 2'd1,
    CLS_SAT    = 2'd2,
    CLS_NAR    = 2'd3
  } posit_class_e;

  function automatic int clog2_f(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        res = i + 1;
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Signed scale must hold k*2^ES + e for the longest regime in either direction.
  function automatic int scale_width_f(input int n, input int es);
    return clog2_f(n) + es + 2;
  endfunction

  function automatic logic [63:0] posit_nar_f(input int n);
    return 64'd1 << (n - 1);
  endfunction

endpackage

// File: rtl/posit_decode_stage_if.sv
// Valid/ready bus for the posit decode stage: raw posit in, decoded fields out.
interface posit_decode_stage_if #(
  parameter int N = 16,
  parameter int S = 4
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_posit;
  logic         out_valid;
  logic         out_ready;
  logic         out_sign;
  logic [N-1:0] out_mant;
  logic [S-1:0] out_shift;
  logic         out_zero;
  logic         out_sat;
  logic         out_nar;

  modport master (
    output in_valid, in_posit, out_ready,
    input  in_ready, out_valid, out_sign, out_mant, out_shift, out_zero, out_sat, out_nar
  );

  modport slave (
    input  in_valid, in_posit, out_ready,
    output in_ready, out_valid, out_sign, out_mant, out_shift, out_zero, out_sat, out_nar
  );
endinterface

// File: rtl/posit_decode_stage_run_count.sv
// Leading-run detector: value of the top bit and how many bits from the top
// repeat it before the first differing bit.
module posit_run_count #(
  parameter int W = 15,
  parameter int S = 4
) (
  input  logic [W-1:0] vec,
  output logic         run,
  output logic [S-1:0] len
);

  logic         done_s;
  logic [S-1:0] cnt_s;

  // Count matching bits from the MSB until the first break
  always_comb begin
    cnt_s  = {S{1'b0}};
    done_s = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (!done_s && (vec[i] == vec[W-1])) begin
        cnt_s = cnt_s + {{(S-1){1'b0}}, 1'b1};
      end else begin
        done_s = 1'b1;
      end
    end
  end

  assign run = vec[W-1];
  assign len = cnt_s;

endmodule

// File: rtl/posit_decode_stage.sv
// Two-stage posit decoder: stage 1 takes sign/specials/magnitude, stage 2 decodes
// regime, exponent and fraction into a mantissa plus right-shift amount.
module posit_decode_stage
  import posit_decode_stage_pkg::*;
#(
  parameter int N  = POSIT_N_DEF,
  parameter int ES = POSIT_ES_DEF,
  parameter int S  = clog2_f(N),
  parameter int SW = scale_width_f(N, ES)
) (
  input  logic                clk,
  input  logic                rst_n,
  posit_decode_stage_if.slave bus
);

  localparam logic [N-1:0]         NAR_WORD  = N'(posit_nar_f(N));
  localparam logic [N-1:0]         ONE_N     = {{(N-1){1'b0}}, 1'b1};
  localparam logic signed [SW-1:0] ONE_SW    = SW'(1);
  localparam logic signed [SW-1:0] ZERO_SW   = {SW{1'b0}};
  localparam logic signed [SW-1:0] SAT_LIM   = SW'(N - 1);
  localparam logic [S-1:0]         SHIFT_TOP = S'(N - 1);

  logic         adv1_s;
  logic         adv2_s;
  logic         v1_r;
  logic         sign1_r;
  logic         zero1_r;
  logic         nar1_r;
  logic [N-2:0] abs1_r;

  logic         v2_r;
  logic         sign2_r;
  logic [N-1:0] mant2_r;
  logic [S-1:0] shift2_r;
  logic         zero2_r;
  logic         sat2_r;
  logic         nar2_r;

  logic                 run_s;
  logic [S-1:0]         len_s;
  logic [S:0]           skip_s;
  logic [N-2:0]         rem_s;
  logic [ES-1:0]        exp_s;
  logic signed [SW-1:0] len_sw_s;
  logic signed [SW-1:0] exp_sw_s;
  logic signed [SW-1:0] k_s;
  logic signed [SW-1:0] scale_s;
  posit_class_e         cls_s;
  logic [N-1:0]         mant_s;
  logic [S-1:0]         shift_s;
  logic                 zero_s;
  logic                 sat_s;
  logic                 nar_s;

  assign adv2_s       = !v2_r || bus.out_ready;
  assign adv1_s       = !v1_r || adv2_s;
  assign bus.in_ready = adv1_s;

  // Stage 1: sign, special patterns and two's-complement magnitude.
  // For every non-special posit the magnitude's top bit is zero, so only N-1 bits are kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r    <= 1'b0;
      sign1_r <= 1'b0;
      zero1_r <= 1'b0;
      nar1_r  <= 1'b0;
      abs1_r  <= {(N-1){1'b0}};
    end else if (adv1_s) begin
      v1_r <= bus.in_valid;
      if (bus.in_valid) begin
        sign1_r <= bus.in_posit[N-1];
        zero1_r <= (bus.in_posit == {N{1'b0}});
        nar1_r  <= (bus.in_posit == NAR_WORD);
        abs1_r  <= (N-1)'(bus.in_posit[N-1] ? (~bus.in_posit + ONE_N) : bus.in_posit);
      end
    end
  end

  posit_run_count #(.W(N - 1), .S(S)) u_run_count (
    .vec (abs1_r),
    .run (run_s),
    .len (len_s)
  );

  // Stage 2 decode: shifting out regime plus terminator leaves exponent then fraction
  // at the top; a full-length regime shifts everything out, giving e=0 and no fraction.
  always_comb begin
    skip_s   = {1'b0, len_s} + {{S{1'b0}}, 1'b1};
    rem_s    = abs1_r << skip_s;
    exp_s    = rem_s[N-2 -: ES];
    len_sw_s = {{(SW-S){1'b0}}, len_s};
    exp_sw_s = {{(SW-ES){1'b0}}, exp_s};
    k_s      = run_s ? (len_sw_s - ONE_SW) : (ZERO_SW - len_sw_s);
    scale_s  = (k_s <<< ES) + exp_sw_s;

    if (nar1_r) begin
      cls_s = CLS_NAR;
    end else if (zero1_r) begin
      cls_s = CLS_ZERO;
    end else if (scale_s >= SAT_LIM) begin
      cls_s = CLS_SAT;
    end else if (scale_s < ZERO_SW) begin
      cls_s = CLS_ZERO;
    end else begin
      cls_s = CLS_NORMAL;
    end

    mant_s  = {N{1'b0}};
    shift_s = {S{1'b0}};
    zero_s  = 1'b0;
    sat_s   = 1'b0;
    nar_s   = 1'b0;
    case (cls_s)
      CLS_NORMAL: begin
        mant_s  = {1'b1, rem_s[N-2-ES:0], {ES{1'b0}}};
        shift_s = SHIFT_TOP - scale_s[S-1:0];
      end
      CLS_ZERO: zero_s = 1'b1;
      CLS_SAT:  sat_s  = 1'b1;
      CLS_NAR:  nar_s  = 1'b1;
      default: begin
        mant_s  = {N{1'b0}};
        shift_s = {S{1'b0}};
      end
    endcase
  end

  // Stage 2 register: holds while downstream stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_r     <= 1'b0;
      sign2_r  <= 1'b0;
      mant2_r  <= {N{1'b0}};
      shift2_r <= {S{1'b0}};
      zero2_r  <= 1'b0;
      sat2_r   <= 1'b0;
      nar2_r   <= 1'b0;
    end else if (adv2_s) begin
      v2_r <= v1_r;
      if (v1_r) begin
        sign2_r  <= sign1_r;
        mant2_r  <= mant_s;
        shift2_r <= shift_s;
        zero2_r  <= zero_s;
        sat2_r   <= sat_s;
        nar2_r   <= nar_s;
      end
    end
  end

  assign bus.out_valid = v2_r;
  assign bus.out_sign  = sign2_r;
  assign bus.out_mant  = mant2_r;
  assign bus.out_shift = shift2_r;
  assign bus.out_zero  = zero2_r;
  assign bus.out_sat   = sat2_r;
  assign bus.out_nar   = nar2_r;

endmodule
